// File: rtl/qam_gen_pkg.sv
// rtl/qam_gen_pkg.sv - shared constants for the QAM symbol source
package qam_gen_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PATTERN = 2'd0;
  localparam mode_t MODE_PRBS    = 2'd1;
  localparam mode_t MODE_COUNT   = 2'd2;
  localparam mode_t MODE_ZERO    = 2'd3;

  // x^7 + x^6 + 1 feedback taps (state bit indices)
  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;
  localparam logic [6:0] PRBS_DEFAULT_SEED = 7'h7F;

  function automatic logic [6:0] fix_seed(input logic [6:0] seed);
    return (seed == 7'h00) ? PRBS_DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/qam_sym_gen_if.sv
// rtl/qam_sym_gen_if.sv - control and symbol signals of the QAM symbol source
interface qam_sym_gen_if #(
  parameter int SYM_BITS = 4
) ();
  logic                enable_cntr;
  logic                restart;
  logic [1:0]          mode;
  logic [SYM_BITS-1:0] sym_out;
  logic                data_change;

  modport master (
    output enable_cntr, restart, mode,
    input  sym_out, data_change
  );

  modport slave (
    input  enable_cntr, restart, mode,
    output sym_out, data_change
  );
endinterface

// File: rtl/prbs7_step.sv
// rtl/prbs7_step.sv - advances a PRBS7 state by N steps, first output bit at MSB
module prbs7_step
  import qam_gen_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [6:0]   state_i,
  output logic [6:0]   state_o,
  output logic [N-1:0] bits_o
);

  logic [6:0] s;

  always_comb begin
    s      = state_i;
    bits_o = '0;
    for (int i = 0; i < N; i++) begin
      bits_o[N-1-i] = s[6];
      s = {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    end
    state_o = s;
  end

endmodule

// File: rtl/qam_sym_gen.sv
// rtl/qam_sym_gen.sv - tick-paced symbol source: pattern, PRBS7, count or zero
module qam_sym_gen
  import qam_gen_pkg::*;
#(
  parameter int                     SYM_BITS      = 4,
  parameter int                     PATTERN_LEN   = 28,
  parameter logic [PATTERN_LEN-1:0] PATTERN       = 28'h6CC1555,
  parameter int                     TICKS_PER_SYM = 512,
  parameter logic [6:0]             LFSR_SEED     = 7'h7F
) (
  input  logic         clock,
  input  logic         reset,
  qam_sym_gen_if.slave bus
);

  localparam int         TCW  = (TICKS_PER_SYM > 1) ? $clog2(TICKS_PER_SYM) : 1;
  localparam logic [6:0] SEED = fix_seed(LFSR_SEED);

  logic                   en_q, en_d;
  logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [6:0]             lfsr_q, lfsr_d;
  logic [SYM_BITS-1:0]    cnt_q, cnt_d;
  logic [SYM_BITS-1:0]    sym_q, sym_d;
  logic                   dc_q, dc_d;

  logic                   rise, boundary;
  logic [6:0]             lfsr_nxt;
  logic [SYM_BITS-1:0]    prbs_bits;

  prbs7_step #(.N(SYM_BITS)) u_prbs (
    .state_i (lfsr_q),
    .state_o (lfsr_nxt),
    .bits_o  (prbs_bits)
  );

  assign rise     = bus.enable_cntr & ~en_q;
  assign boundary = rise && (tick_cnt_q == TCW'(TICKS_PER_SYM - 1));

  always_comb begin
    en_d       = bus.enable_cntr;
    tick_cnt_d = tick_cnt_q;
    pat_d      = pat_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    dc_d       = 1'b0;
    // restart clears everything except edge history, and suppresses any boundary
    if (bus.restart) begin
      tick_cnt_d = '0;
      pat_d      = PATTERN;
      lfsr_d     = SEED;
      cnt_d      = '0;
      sym_d      = '0;
    end else if (boundary) begin
      tick_cnt_d = '0;
      dc_d       = 1'b1;
      case (bus.mode)
        MODE_PATTERN: begin
          sym_d = pat_q[PATTERN_LEN-1 -: SYM_BITS];
          pat_d = (pat_q << SYM_BITS) | (pat_q >> (PATTERN_LEN - SYM_BITS));
        end
        MODE_PRBS: begin
          sym_d  = prbs_bits;
          lfsr_d = lfsr_nxt;
        end
        MODE_COUNT: begin
          sym_d = cnt_q;
          cnt_d = cnt_q + 1'b1;
        end
        default: sym_d = '0;
      endcase
    end else if (rise) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      en_q       <= 1'b1;
      tick_cnt_q <= '0;
      pat_q      <= PATTERN;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      sym_q      <= '0;
      dc_q       <= 1'b0;
    end else begin
      en_q       <= en_d;
      tick_cnt_q <= tick_cnt_d;
      pat_q      <= pat_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      dc_q       <= dc_d;
    end
  end

  assign bus.sym_out     = sym_q;
  assign bus.data_change = dc_q;

endmodule

// File: tb/tb_qam_sym_gen.sv
// tb/tb_qam_sym_gen.sv - directed bench with index-based reference model
module tb_qam_sym_gen;
  import qam_gen_pkg::*;

  localparam int          T   = 4;
  localparam int          SB  = 4;
  localparam int          PL  = 28;
  localparam logic [27:0] PAT = 28'h6CC1555;
  localparam int          NPAT = PL / SB;

  logic clock = 1'b0;
  logic reset = 1'b0;

  qam_sym_gen_if #(.SYM_BITS(SB)) bus ();

  qam_sym_gen #(.SYM_BITS(SB), .PATTERN_LEN(PL), .PATTERN(PAT),
                .TICKS_PER_SYM(T), .LFSR_SEED(7'h7F)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int dc_seen = 0;
  bit chk_on = 1'b0;
  bit prbs_seq [127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model tracks positions into each source's output stream rather than register state
  int         m_tick, m_pidx, m_bidx, m_cnt;
  logic       m_en;
  logic [3:0] m_sym;
  logic       m_dc;

  function automatic logic [3:0] pat_sym(input int idx);
    logic [27:0] p;
    p = PAT >> (PL - SB * (idx + 1));
    return p[3:0];
  endfunction

  function automatic logic [3:0] prbs_sym(input int idx);
    logic [3:0] r;
    for (int k = 0; k < SB; k++) r[SB-1-k] = prbs_seq[(idx + k) % 127];
    return r;
  endfunction

  always @(posedge clock) begin
    m_en <= bus.enable_cntr;
    if (!reset || bus.restart) begin
      if (!reset) m_en <= 1'b1;
      m_tick <= 0; m_pidx <= 0; m_bidx <= 0; m_cnt <= 0;
      m_sym  <= 4'h0; m_dc <= 1'b0;
    end else begin
      m_dc <= 1'b0;
      if (bus.enable_cntr && !m_en) begin
        if (m_tick == T - 1) begin
          m_tick <= 0;
          m_dc   <= 1'b1;
          case (bus.mode)
            2'd0: begin m_sym <= pat_sym(m_pidx); m_pidx <= (m_pidx + 1) % NPAT; end
            2'd1: begin m_sym <= prbs_sym(m_bidx); m_bidx <= (m_bidx + SB) % 127; end
            2'd2: begin m_sym <= 4'(m_cnt); m_cnt <= (m_cnt + 1) % 16; end
            default: m_sym <= 4'h0;
          endcase
        end else begin
          m_tick <= m_tick + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check("sym_out", 32'(bus.sym_out), 32'(m_sym));
      check("data_change", 32'(bus.data_change), 32'(m_dc));
      if (bus.data_change) dc_seen++;
    end
  end

  task automatic pulse();
    @(negedge clock) bus.enable_cntr = 1'b1;
    @(negedge clock) bus.enable_cntr = 1'b0;
    #1;
  endtask

  task automatic send_sym();
    repeat (T) pulse();
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    #1;
  endtask

  logic [3:0] pat_tbl [8] = '{4'h6, 4'hC, 4'hC, 4'h1, 4'h5, 4'h5, 4'h5, 4'h6};
  int base;

  initial begin
    logic [6:0] s;
    s = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_seq[i] = s[6];
      s = {s[5:0], s[6] ^ s[5]};
    end

    bus.enable_cntr = 1'b1;
    bus.restart     = 1'b0;
    bus.mode        = 2'd0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    chk_on = 1'b1;
    repeat (3) @(negedge clock);
    bus.enable_cntr = 1'b0;
    @(negedge clock); #1;
    check("reset_sym", 32'(bus.sym_out), 32'h0);
    check("reset_dc", 32'(bus.data_change), 32'h0);

    // held-high enable across reset must not count: 3 pulses stay inside symbol 0
    repeat (T - 1) pulse();
    check("no_early_boundary", 32'(dc_seen), 32'd0);
    pulse();
    check("pat_0", 32'(bus.sym_out), 32'(pat_tbl[0]));
    for (int i = 1; i < 8; i++) begin
      send_sym();
      check($sformatf("pat_%0d", i), 32'(bus.sym_out), 32'(pat_tbl[i]));
    end
    check("pat_dc_count", 32'(dc_seen), 32'd8);

    // mode switching resumes each source
    do_reset();
    send_sym(); check("sw_pat0", 32'(bus.sym_out), 32'h6);
    send_sym(); check("sw_pat1", 32'(bus.sym_out), 32'hC);
    bus.mode = 2'd1;
    send_sym(); check("prbs_0", 32'(bus.sym_out), 32'hF);
    repeat (2) pulse();
    bus.mode = 2'd0;
    repeat (1) pulse();
    check("mode_change_hold", 32'(bus.sym_out), 32'hF);
    pulse();
    check("sw_pat2", 32'(bus.sym_out), 32'hC);
    bus.mode = 2'd1;
    send_sym(); check("prbs_1", 32'(bus.sym_out), 32'hE);

    // count mode over a full wrap
    do_reset();
    bus.mode = 2'd2;
    base = dc_seen;
    for (int i = 0; i < 17; i++) begin
      send_sym();
      check($sformatf("cnt_%0d", i), 32'(bus.sym_out), 32'(i % 16));
    end
    check("cnt_dc_count", 32'(dc_seen - base), 32'd17);
    bus.mode = 2'd3;
    send_sym(); check("zero_mode", 32'(bus.sym_out), 32'h0);
    bus.mode = 2'd2;
    send_sym(); check("cnt_resume", 32'(bus.sym_out), 32'h1);

    // restart on a boundary rise
    do_reset();
    bus.mode = 2'd0;
    send_sym(); send_sym();
    repeat (T - 1) pulse();
    base = dc_seen;
    @(negedge clock) begin bus.enable_cntr = 1'b1; bus.restart = 1'b1; end
    @(negedge clock) begin bus.enable_cntr = 1'b0; bus.restart = 1'b0; end
    #1;
    check("restart_no_dc", 32'(dc_seen - base), 32'd0);
    check("restart_sym", 32'(bus.sym_out), 32'h0);
    repeat (T - 1) pulse();
    check("restart_tick0", 32'(dc_seen - base), 32'd0);
    pulse();
    check("restart_pat", 32'(bus.sym_out), 32'h6);

    // reset in the middle of a symbol
    send_sym();
    repeat (2) pulse();
    do_reset();
    base = dc_seen;
    send_sym();
    check("midreset_dc", 32'(dc_seen - base), 32'd1);
    check("midreset_pat", 32'(bus.sym_out), 32'h6);

    repeat (3) @(negedge clock);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
